// File: rtl/key_expand_if.sv
// rtl/key_expand_if.sv - key_expand control, key and round-key read bus.
// KEY_EXPAND_ZEROIZE_EN adds the zeroize request line.
interface key_expand_if #(
   parameter int KEY_BITS = 128
) ();
   logic                start;
   logic [KEY_BITS-1:0] key_in;
   logic                busy;
   logic                done;
   logic                keys_valid;
   logic [3:0]          rd_round;
   logic [127:0]        rd_key;
`ifdef KEY_EXPAND_ZEROIZE_EN
   logic                zeroize;
`endif

   modport master (
`ifdef KEY_EXPAND_ZEROIZE_EN
      output zeroize,
`endif
      output start, key_in, rd_round,
      input  busy, done, keys_valid, rd_key
   );

   modport slave (
`ifdef KEY_EXPAND_ZEROIZE_EN
      input  zeroize,
`endif
      input  start, key_in, rd_round,
      output busy, done, keys_valid, rd_key
   );
endinterface

// File: rtl/key_expand.sv
// rtl/key_expand.sv - iterative AES key schedule (128/192/256), one word per clock.
// KEY_EXPAND_ZEROIZE_EN adds a zeroize input that wipes the stored schedule.
module sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
   function automatic logic [7:0] subst(input logic [7:0] a);
      logic [7:0] s;
      logic [7:0] acc;
      s   = a;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         s   = gmul(s, s);
         acc = gmul(acc, s);
      end
      return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
                 ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
   endfunction

   assign out_o = subst(in_i);
endmodule

module key_expand #(
   parameter int KEY_BITS = 128
) (
   input logic         clk,
   input logic         rst,
   key_expand_if.slave ke
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [5:0] NK6     = 6'(NK);
   localparam logic [5:0] LAST_W  = 6'(NW - 1);
   localparam logic [2:0] NK_LAST = 3'(NK - 1);
   localparam logic [3:0] NR4     = 4'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("key_expand: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t      state_q;
   logic [31:0] w_q [NW];
   logic [5:0]  idx_q;
   logic [2:0]  mod_q;
   logic [7:0]  rcon_q;
   logic        busy_q;
   logic        done_q;
   logic        valid_q;

   logic [31:0] prev_w;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp_d;
   logic [31:0] word_d;
   logic [2:0]  mod_d;
   logic [7:0]  rcon_d;
   logic [5:0]  rd_base;

   assign prev_w = w_q[idx_q - 6'd1];
   assign sub_in = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      sbox u_sbox (.in_i(sub_in[8*b +: 8]), .out_o(sub_out[8*b +: 8]));
   end

   always_comb begin
      temp_d = prev_w;
      if (mod_q == 3'd0) begin
         temp_d = sub_out ^ {rcon_q, 24'h000000};
      end else if (NK == 8 && mod_q == 3'd4) begin
         temp_d = sub_out;
      end
      word_d = w_q[idx_q - NK6] ^ temp_d;
      mod_d  = (mod_q == NK_LAST) ? 3'd0 : mod_q + 3'd1;
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 6'd0;
         mod_q   <= 3'd0;
         rcon_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
      end
`ifdef KEY_EXPAND_ZEROIZE_EN
      else if (ke.zeroize) begin
         state_q <= IDLE;
         idx_q   <= 6'd0;
         mod_q   <= 3'd0;
         rcon_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
      end
`endif
      else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ke.start) begin
                  for (int k = 0; k < NK; k++) begin
                     w_q[k] <= ke.key_in[KEY_BITS-1-32*k -: 32];
                  end
                  idx_q   <= NK6;
                  mod_q   <= 3'd0;
                  rcon_q  <= 8'h01;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= EXPAND;
               end
            end
            EXPAND: begin
               w_q[idx_q] <= word_d;
               idx_q      <= idx_q + 6'd1;
               mod_q      <= mod_d;
               if (mod_q == 3'd0) rcon_q <= rcon_d;
               if (idx_q == LAST_W) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Round r occupies words 4r..4r+3; rounds beyond NR read as zero.
   assign rd_base = {ke.rd_round, 2'b00};

   always_comb begin
      ke.rd_key = 128'h0;
      if (valid_q && ke.rd_round <= NR4) begin
         ke.rd_key = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
      end
   end

   assign ke.busy       = busy_q;
   assign ke.done       = done_q;
   assign ke.keys_valid = valid_q;
endmodule
